// File: rtl/ext_flash_reader_pkg.sv
// ext_flash_pkg: shared types and constants for the external flash reader.
//   state_t          - transaction FSM states
//   *_BITS           - SPI frame field lengths (opcode, address, data)
//   FLASH_ADDR_W     - width of the flash-side byte address
//   DEFAULT_READ_CMD - standard serial-flash READ opcode
//   order_and_mask   - maps the received bit stream onto the returned word
package ext_flash_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, HOLD, DONE} state_t;

  localparam int CMD_BITS     = 8;
  localparam int ADDR_BITS    = 24;
  localparam int DATA_BITS    = 32;
  localparam int FLASH_ADDR_W = 24;

  localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

  // rx holds the stream MSB-first, so the first received byte sits in
  // rx[31:24]; it belongs in byte lane 0 of the returned word.
  function automatic logic [31:0] order_and_mask(input logic [31:0] rx,
                                                 input logic [3:0]  be);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? rx[31-8*i -: 8] : 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/ext_flash_reader_if.sv
// ext_flash_reader_if: word-read request/response bus between the storage
// path (master) and the external flash reader (slave).
//   memory_access      - request, held high until out_valid
//   memory_is_writing  - write request (rejected with err)
//   addr / mem_be      - CPU byte address and byte enables
//   d_out / out_valid  - read data and one-cycle completion pulse
//   err                - one-cycle error pulse, coincident with out_valid
//   busy               - transaction in progress
interface ext_flash_reader_if;
  import ext_flash_pkg::*;

  logic        memory_access;
  logic        memory_is_writing;
  logic [31:0] addr;
  logic [3:0]  mem_be;
  logic [31:0] d_out;
  logic        out_valid;
  logic        err;
  logic        busy;

  modport master (
    output memory_access, memory_is_writing, addr, mem_be,
    input  d_out, out_valid, err, busy
  );

  modport slave (
    input  memory_access, memory_is_writing, addr, mem_be,
    output d_out, out_valid, err, busy
  );

endinterface

// File: rtl/ext_flash_reader_spi_clk_gen.sv
// spi_clk_gen: SCK divider for the flash reader. Each SCK half-period lasts
// CLK_DIV clk cycles, starting low.
//   clk, rst - system clock, asynchronous active-high reset
//   en       - run the divider; when low sck parks at 0 and the count clears
//   hold     - suppress the next rising edge (sck stays low)
//   sck      - SPI clock (mode 0)
//   tick     - last cycle of the current half-period
//   rise     - sck goes high at the end of this cycle
//   fall     - sck goes low at the end of this cycle
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;

  logic [CNT_W-1:0] div_cnt;
  logic             at_edge;

  assign at_edge = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign tick    = en && at_edge;
  assign rise    = tick && !sck && !hold;
  assign fall    = tick && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (at_edge) begin
      div_cnt <= '0;
      // A held low phase ends without rising so an abort never emits a
      // partial SCK pulse.
      sck     <= sck ? 1'b0 : !hold;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ext_flash_reader.sv
// ext_flash_reader: read-only SPI master serving 32-bit external-storage
// reads. Issues READ_CMD + 24-bit address, shifts in 32 data bits and
// returns the word with a one-cycle out_valid pulse.
//   clk, rst       - system clock, asynchronous active-high reset
//   bus (slave)    - request/response bus, see ext_flash_reader_if
//   spi_cs_n       - flash chip select, active low
//   spi_sck        - SPI clock, mode 0
//   spi_mosi       - master out
//   spi_miso       - master in
module ext_flash_reader
  import ext_flash_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_2000,
  parameter int          CS_SETUP  = 1,
  parameter int          CS_HOLD   = 1,
  parameter logic [7:0]  READ_CMD  = DEFAULT_READ_CMD
) (
  input  logic                clk,
  input  logic                rst,
  ext_flash_reader_if.slave   bus,
  output logic                spi_cs_n,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  state_t                  state, next_state;
  logic [15:0]             tmr;
  logic [5:0]              bit_cnt;
  logic                    aborted;
  logic [31:0]             tx_sr;
  logic [31:0]             rx_sr;
  logic [3:0]              be_q;
  logic [31:0]             d_out_r;
  logic                    out_valid_r, err_r, busy_r;
  logic [31:0]             offset;
  logic [FLASH_ADDR_W-1:0] flash_addr;
  logic                    req_err, shifting, abort_req;
  logic                    tick, rise, fall;

  assign offset     = bus.addr - ADDR_BASE;
  assign flash_addr = offset[FLASH_ADDR_W-1:0] & 24'hFF_FFFC;
  assign req_err    = bus.memory_is_writing || (bus.addr < ADDR_BASE) ||
                      (offset[31:FLASH_ADDR_W] != '0);
  assign shifting   = (state == CMD) || (state == ADDR) || (state == DATA);
  assign abort_req  = !bus.memory_access;

  assign bus.d_out     = d_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (shifting),
    .hold (abort_req),
    .sck  (spi_sck),
    .tick (tick),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (bus.memory_access) next_state = req_err ? DONE : SETUP;
      SETUP: if (abort_req)         next_state = HOLD;
             else if (tmr == '0)    next_state = CMD;
      CMD, ADDR, DATA: begin
        // An abort leaves at the end of the current half-period.
        if (abort_req && tick)
          next_state = HOLD;
        else if (fall && bit_cnt == '0)
          next_state = (state == CMD) ? ADDR : (state == ADDR) ? DATA : HOLD;
      end
      HOLD:  if (tmr == '0) next_state = aborted ? IDLE : DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control: state, counters and all registered pin/bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      bit_cnt     <= '0;
      aborted     <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_mosi    <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      d_out_r     <= '0;
    end else begin
      state       <= next_state;
      spi_cs_n    <= !(next_state inside {SETUP, CMD, ADDR, DATA, HOLD});
      busy_r      <= (next_state != IDLE);
      out_valid_r <= (next_state == DONE);
      err_r       <= (state == IDLE) && (next_state == DONE);

      if (state == IDLE)
        aborted <= 1'b0;
      else if (abort_req && next_state == HOLD && state != HOLD)
        aborted <= 1'b1;

      if (next_state != state) begin
        case (next_state)
          SETUP:   tmr     <= 16'(CS_SETUP - 1);
          HOLD:    tmr     <= 16'(CS_HOLD - 1);
          CMD:     bit_cnt <= 6'(CMD_BITS - 1);
          ADDR:    bit_cnt <= 6'(ADDR_BITS - 1);
          DATA:    bit_cnt <= 6'(DATA_BITS - 1);
          default: ;
        endcase
      end else if (state == SETUP || state == HOLD) begin
        tmr <= tmr - 1'b1;
      end else if (fall) begin
        bit_cnt <= bit_cnt - 1'b1;
      end

      // MOSI changes only at the start of a low half-period; the shift
      // register drains to zeros, so DATA sends 0 without a special case.
      if (state == SETUP && next_state == CMD)
        spi_mosi <= tx_sr[31];
      else if (shifting && fall)
        spi_mosi <= tx_sr[30];
      if (!(next_state inside {CMD, ADDR, DATA}))
        spi_mosi <= 1'b0;

      if (state == IDLE && bus.memory_access)
        d_out_r <= '0;
      else if (state == HOLD && next_state == DONE)
        d_out_r <= order_and_mask(rx_sr, be_q);
    end
  end

  // Datapath: request capture and the two shift registers.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.memory_access) begin
      be_q  <= bus.mem_be;
      tx_sr <= {READ_CMD, flash_addr};
    end else if (shifting && fall) begin
      tx_sr <= {tx_sr[30:0], 1'b0};
    end
    if (state == DATA && rise)
      rx_sr <= {rx_sr[30:0], spi_miso};
  end

endmodule

// File: doc/ext_flash_reader.md
Name: ext_flash_reader

Overview:
Read-only SPI master that services external-storage word reads (0x0000_2000 and above) on behalf of the storage path downstream of the MMU. It accepts a level-held request, issues a standard flash READ (0x03) with a 24-bit address, and shifts in 32 data bits. It then returns the word with a one-cycle valid pulse. It drives the external flash SPI pins directly.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period; legal range is 1 or more.
ADDR_BASE, 32'h0000_2000, CPU address that maps to flash address 0.
CS_SETUP, 1, clk cycles with cs_n low before the first SCK rise.
CS_HOLD, 1, clk cycles with cs_n low after the last SCK fall.
READ_CMD, 8'h03, flash read opcode.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
memory_access  input  1  request; held high until out_valid
memory_is_writing  input  1  write request, which is illegal (flash is read-only)
addr  input  32  CPU byte address
mem_be  input  4  byte enables; disabled bytes are returned as 0
d_out  output  32  read data, valid while out_valid is high
out_valid  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with out_valid
busy  output  1  high from the cycle after acceptance through DONE
spi_cs_n  output  1  flash chip select, active low
spi_sck  output  1  SPI clock, mode 0
spi_mosi  output  1  master out
spi_miso  input  1  master in

Behaviour:
- Reset values (asynchronous on rst=1): spi_cs_n=1, spi_sck=0, spi_mosi=0, d_out=0, out_valid=0, err=0, busy=0, state=IDLE. Reset mid-transaction drops cs_n immediately, and no out_valid is issued.
- Acceptance: in IDLE, memory_access=1 is sampled. On that cycle the block latches addr, mem_be and memory_is_writing. Later input changes are ignored.
- Error requests: an error request is one where memory_is_writing=1, or addr<ADDR_BASE, or (addr-ADDR_BASE)>=2^24.
  - The block goes to DONE on the next cycle with out_valid=1, err=1, d_out=0.
  - No SPI activity occurs.
- Flash address: (addr-ADDR_BASE)[23:0] with bits [1:0] forced to 0, so reads are word-aligned.
- States: IDLE -> SETUP (CS_SETUP cycles) -> CMD (8 bits) -> ADDR (24 bits) -> DATA (32 bits) -> HOLD (CS_HOLD cycles) -> DONE (1 cycle) -> IDLE.
- SETUP through HOLD: spi_cs_n=0. In SETUP and HOLD, spi_sck=0.
- Bit timing: each bit is CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high.
  - MOSI is updated at the start of the low half, MSB first.
  - MISO is sampled on the clk edge where sck goes high.
- MOSI content: opcode in CMD, address in ADDR, 0 in DATA. MISO is ignored outside DATA.
- Byte order: the first received byte goes to d_out[7:0], the second to [15:8], and so on; each byte is MSB first. Bytes with mem_be[i]=0 are forced to 0 at DONE.
- DONE: spi_cs_n=1, out_valid=1, err=0. d_out is held until the next acceptance.
- Latency: out_valid fires exactly CS_SETUP + 128*CLK_DIV + CS_HOLD + 1 cycles after the acceptance cycle. With default parameters this is 259.
- Back-to-back requests: IDLE is re-entered after DONE, and a new acceptance is possible on the cycle after DONE. A memory_access still high in that cycle is treated as a new request.
- Abort: if memory_access drops during SETUP, CMD, ADDR or DATA, the block behaves as follows.
  - It completes the current SCK low phase, then forces sck=0.
  - It enters HOLD, then returns to IDLE. DONE is not visited, so there is no out_valid.
- Counters:
  - The bit counter is 6 bits and counts down within each phase; there is no wrap-around across phases.
  - The divider counter is $clog2(CLK_DIV)+1 bits wide and resets to 0 at every phase change.

Decomposition:
- Package ext_flash_pkg holds: the state enum (IDLE, SETUP, CMD, ADDR, DATA, HOLD, DONE), CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32, FLASH_ADDR_W=24, and the default READ_CMD.
- Sub-module spi_clk_gen: CLK_DIV divider with an enable input. It produces sck plus single-cycle rise and fall strobes, and returns to sck=0 when disabled.

Test Plan:
1. Read at addr=0x0000_2004, mem_be=4'hF; flash model returns bytes 0x11,0x22,0x33,0x44 -> MOSI shows 0x03 then 0x000004; d_out=0x4433_2211; out_valid at cycle 259; err=0.
2. mem_be=4'b0101 on the same data -> d_out=0x0033_0011.
3. memory_is_writing=1 at 0x0000_3000 -> out_valid=1 and err=1 on the next cycle; cs_n never goes low.
4. addr=0x0100_2000 (offset 2^24) -> err pulse; addr=0x0000_2002 -> flash address 0x000000 on MOSI.
5. memory_access dropped after 20 SCK bits -> cs_n returns high after CS_HOLD, no out_valid, and the next request completes normally.
6. rst asserted during DATA -> cs_n=1, sck=0 and out_valid=0 in the same cycle; with CLK_DIV=1, the back-to-back request latency is 131 cycles.
